// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux channel among four requesters.
// A grant is held while requested; the owner is preempted after MAX_HOLD cycles if others wait.
`timescale 1ns/1ps
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_req,
    output logic [3:0] o_grant,
    output logic [1:0] o_sel,
    output logic       o_busy
);
    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    sel_q, sel_d;
    logic          busy_q, busy_d;

    logic [3:0]    others;
    logic [2:0]    pick_all;
    logic [2:0]    pick_oth;
    logic          take;
    logic [1:0]    win;

    // Returns {found, index}; the search begins just after last and ends on last itself.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        take     = 1'b0;
        win      = 2'd0;
        others   = i_req & ~(4'b0001 << sel_q);
        pick_all = rr_pick(i_req, last_q);
        pick_oth = rr_pick(others, last_q);

        case (state_q)
            IDLE: begin
                if (pick_all[2]) begin
                    take = 1'b1;
                    win  = pick_all[1:0];
                end
            end
            GRANT: begin
                if (!i_req[sel_q]) begin
                    if (pick_all[2]) begin
                        take = 1'b1;
                        win  = pick_all[1:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (MAX_HOLD != 0 && cnt_q == CW'(MAX_HOLD) && pick_oth[2]) begin
                    take = 1'b1;
                    win  = pick_oth[1:0];
                end else if (MAX_HOLD != 0 && cnt_q != CW'(MAX_HOLD)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = GRANT;
            grant_d = 4'b0001 << win;
            sel_d   = win;
            busy_d  = 1'b1;
            last_d  = win;
            cnt_d   = CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign o_grant = grant_q;
    assign o_sel   = sel_q;
    assign o_busy  = busy_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with MAX_HOLD=4; outputs sampled 1ns after the rising edge.
`timescale 1ns/1ps
module tb_mux_rr_arbiter;
    logic       clk;
    logic       reset;
    logic [3:0] i_req;
    logic [3:0] o_grant;
    logic [1:0] o_sel;
    logic       o_busy;

    int n_checks;
    int n_errors;

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .o_grant (o_grant),
        .o_sel   (o_sel),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        i_req = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int g, input int s, input int b);
        check({tag, "_grant"}, int'(o_grant), g);
        check({tag, "_sel"},   int'(o_sel),   s);
        check({tag, "_busy"},  int'(o_busy),  b);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        i_req    = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        chk_all("reset", 'h0, 0, 0);

        // single request from idle, then release
        i_req = 4'b0100;
        tick();
        chk_all("t2_grant", 'h4, 2, 1);
        i_req = 4'b0000;
        tick();
        check("t2_idle_grant", int'(o_grant), 'h0);
        check("t2_idle_busy",  int'(o_busy),  0);
        check("t2_idle_sel",   int'(o_sel),   2);

        // asynchronous reset with no clock edge
        i_req = 4'b1000;
        tick();
        chk_all("t1_pre", 'h8, 3, 1);
        reset = 1'b1;
        #1;
        chk_all("t1_async", 'h0, 0, 0);
        i_req = 4'b0000;
        tick();
        reset = 1'b0;

        // all request; each owner releases after two cycles of ownership
        i_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all($sformatf("t3_own%0d_a", k), 1 << k, k, 1);
            tick();
            chk_all($sformatf("t3_own%0d_b", k), 1 << k, k, 1);
            i_req[k] = 1'b0;
        end
        tick();
        chk_all("t3_end", 'h0, 3, 0);

        // preemption with two competing requesters
        apply_reset();
        i_req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_all($sformatf("t4_r0_c%0d", c), 'h1, 0, 1);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_all($sformatf("t4_r1_c%0d", c), 'h2, 1, 1);
        end
        tick();
        chk_all("t4_back0", 'h1, 0, 1);

        // lone requester is never preempted
        apply_reset();
        i_req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("t5_c%0d", c), int'(o_grant), 'h1);
        end

        // release with handover in RR order, then reset during the grant
        apply_reset();
        i_req = 4'b0010;
        tick();
        chk_all("t6_own1", 'h2, 1, 1);
        i_req = 4'b1001;
        tick();
        chk_all("t6_own3", 'h8, 3, 1);
        reset = 1'b1;
        #1;
        chk_all("t6_rst", 'h0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        chk_all("t6_own0", 'h1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
